// File: rtl/mem_arbiter.sv
// N-channel arbiter granting the single mem_cntrl port to one requester at a time.
// Define MEM_ARB_RR_EN for round-robin selection; left undefined, the lowest eligible index wins.
module mem_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int IDW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]            ch_r_en,
  input  logic [NUM_CH-1:0]            ch_w_en,
  output logic [NUM_CH-1:0]            ch_rdy,
  output logic [NUM_CH-1:0]            ch_cplt,
  output logic [DATA_WIDTH-1:0]        ch_data_out,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_data_in,
  output logic                         mem_r_en,
  output logic                         mem_w_en,
  input  logic                         mem_rdy,
  input  logic                         mem_cplt,
  input  logic [DATA_WIDTH-1:0]        mem_data_out,
  output logic                         busy,
  output logic [IDW-1:0]               grant_id
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0]     elig;
  logic [NUM_CH-1:0]     rot;
  logic                  found;
  logic [IDW-1:0]        win_id;

  assign elig = ch_en & (ch_r_en | ch_w_en);

`ifdef MEM_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  int             idx;

  // Search wraps from the pointer, which sits one past the last winner.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    idx    = 0;
    rot    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx -= NUM_CH;
      rot = elig >> idx;
      if (!found && rot[0]) begin
        found  = 1'b1;
        win_id = IDW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && mem_rdy && found)
      ptr_d = (int'(win_id) == NUM_CH - 1) ? '0 : win_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    rot    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      rot = elig >> k;
      if (rot[0]) begin
        found  = 1'b1;
        win_id = IDW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_rdy && found) begin
          state_d = S_ISSUE;
          grant_d = win_id;
          // A simultaneous read and write request resolves to the write.
          wr_d    = ch_w_en[win_id];
          addr_d  = ADDR_WIDTH'(ch_addr >> (win_id * ADDR_WIDTH));
          wdata_d = DATA_WIDTH'(ch_data_in >> (win_id * DATA_WIDTH));
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_cplt) begin
          rdata_d = mem_data_out;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory-side outputs come only from registered state.
  assign busy        = (state_q != S_IDLE);
  assign ch_rdy      = (state_q == S_IDLE && mem_rdy) ? ch_en : '0;
  assign ch_cplt     = (state_q == S_DONE) ? (NUM_CH'(1) << grant_q) : '0;
  assign ch_data_out = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_r_en    = (state_q == S_ISSUE) && !wr_q;
  assign mem_w_en    = (state_q == S_ISSUE) && wr_q;
  assign grant_id    = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter (4 channels): directed scenarios plus randomized traffic against a request-table model.
module tb_mem_arbiter;
  localparam int NCH = 4;
  localparam int AW  = 24;
  localparam int DW  = 16;

  logic                    clk;
  logic                    rst_n;
  logic [NCH-1:0]          en, pr, pw;
  logic [NCH-1:0][AW-1:0]  addr;
  logic [NCH-1:0][DW-1:0]  wdat;
  logic [NCH-1:0]          ch_rdy, ch_cplt;
  logic [DW-1:0]           ch_data_out;
  logic [AW-1:0]           mem_addr;
  logic [DW-1:0]           mem_data_in;
  logic                    mem_r_en, mem_w_en;
  logic                    mem_rdy, mem_cplt;
  logic [DW-1:0]           mem_dout;
  logic                    busy;
  logic [1:0]              grant_id;

  int n_cmp, n_err;
  int m_last;  // last granted channel in the model, -1 after reset

  mem_arbiter #(.NUM_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .ch_en(en), .ch_addr(addr), .ch_data_in(wdat),
    .ch_r_en(pr), .ch_w_en(pw), .ch_rdy(ch_rdy), .ch_cplt(ch_cplt),
    .ch_data_out(ch_data_out), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_rdy(mem_rdy), .mem_cplt(mem_cplt),
    .mem_data_out(mem_dout), .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Winner among enabled channels holding a read or write request.
  function automatic int model_pick();
    int best;
    best = -1;
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (m_last + 1 + k) % NCH;
      if (best < 0 && en[c] && (pr[c] || pw[c])) best = c;
    end
`else
    for (int c = NCH - 1; c >= 0; c--)
      if (en[c] && (pr[c] || pw[c])) best = c;
`endif
    return best;
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_cplt_rdy"}, {ch_cplt, ch_rdy}, 0);
    check({tag, "_strobes"}, {mem_r_en, mem_w_en}, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_data_in"}, mem_data_in, 0);
    check({tag, "_ch_data_out"}, ch_data_out, 0);
    check({tag, "_grant_id"}, grant_id, 0);
  endtask

  // Called at a negedge in IDLE with requests already driven; plays the memory side.
  task automatic step(input int lat_i, input logic [DW-1:0] rd_i, output int gid_o,
                      output logic we_o, output logic [DW-1:0] din_o, output int ncyc_o);
    int w, lat, ncyc;
    logic wr;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, rd;
    logic [NCH-1:0] en_save;
    w = mem_rdy ? model_pick() : -1;
    gid_o = -1; we_o = 1'b0; din_o = '0; ncyc = 0;
    #1;
    check("ch_rdy_idle", ch_rdy, mem_rdy ? en : '0);
    @(negedge clk); ncyc++;
    if (w < 0) begin
      check("no_grant", {busy, mem_r_en, mem_w_en}, 0);
      ncyc_o = ncyc;
      return;
    end
    wr = pw[w]; ea = addr[w]; ed = wdat[w];
    m_last = w;
    gid_o = int'(grant_id); we_o = mem_w_en; din_o = mem_data_in;
    check("grant_id", grant_id, w);
    check("mem_w_en", mem_w_en, wr);
    check("mem_r_en", mem_r_en, !wr);
    check("mem_addr", mem_addr, ea);
    check("mem_data_in", mem_data_in, ed);
    check("issue_busy", busy, 1);
    check("issue_rdy_cplt", {ch_rdy, ch_cplt}, 0);
    // Inputs changing in flight must not disturb the operation.
    en_save = en;
    en = NCH'($urandom);
    addr[w] = AW'($urandom);
    mem_rdy = 1'($urandom);
    lat = (lat_i > 0) ? lat_i : $urandom_range(1, 4);
    repeat (lat - 1) begin
      @(negedge clk); ncyc++;
      check("wait_quiet", {mem_r_en, mem_w_en, ch_cplt}, 0);
      check("wait_hold_addr", mem_addr, ea);
    end
    rd = (lat_i > 0) ? rd_i : DW'($urandom);
    @(negedge clk); ncyc++;
    mem_cplt = 1'b1; mem_dout = rd;
    @(negedge clk); ncyc++;
    mem_cplt = 1'b0; mem_dout = DW'($urandom);
    check("ch_cplt", ch_cplt, 64'(1) << w);
    check("ch_data_out", ch_data_out, rd);
    pr[w] = 1'b0; pw[w] = 1'b0;
    en = en_save; mem_rdy = 1'b1;
    ncyc_o = ncyc;
  endtask

  initial begin
    int g, nc, k;
    logic we;
    logic [DW-1:0] din;
    int exp_cont[4];
    int exp_rr4[3];
`ifdef MEM_ARB_RR_EN
    exp_cont = '{0, 1, 0, 1};
    exp_rr4  = '{2, 3, 1};
`else
    exp_cont = '{0, 0, 0, 0};
    exp_rr4  = '{1, 2, 3};
`endif
    n_cmp = 0; n_err = 0; m_last = -1;
    rst_n = 1'b0; en = '0; pr = '0; pw = '0; addr = '0; wdat = '0;
    mem_rdy = 1'b0; mem_cplt = 1'b0; mem_dout = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset("por");
    mem_rdy = 1'b1;

    // Single read: ch1 at 0x10, memory answers 0xBEEF after 5 cycles.
    @(negedge clk);
    en = '1; pr[1] = 1'b1; addr[1] = 24'h000010;
    step(5, 16'hBEEF, g, we, din, nc);
    check("rd_grant", g, 1);
    check("rd_latency", nc, 7);

    // Contention between ch0 and ch1 with both re-requesting at once.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      en = '1; pr[0] = 1'b1; pr[1] = 1'b1; pw[0] = 1'b0; pw[1] = 1'b0;
      step(0, '0, g, we, din, nc);
      check("contention_order", g, exp_cont[i]);
    end

    // Disabled requester is never granted until enabled.
    @(negedge clk);
    pr = '0; pw = '0; pr[1] = 1'b1; en = 4'b0001;
    #1 check("dis_rdy", ch_rdy, 4'b0001);
    repeat (3) begin
      @(negedge clk);
      check("dis_busy", busy, 0);
    end
    en = 4'b0011;
    step(0, '0, g, we, din, nc);
    check("dis_grant", g, 1);

    // Read and write together resolve to a write.
    @(negedge clk);
    en = '1; pr[0] = 1'b1; pw[0] = 1'b1; wdat[0] = 16'h1234;
    step(0, '0, g, we, din, nc);
    check("rw_w_en", we, 1);
    check("rw_data", din, 16'h1234);

    // Reset while waiting on memory abandons the operation.
    @(negedge clk);
    en = '1; pw[2] = 1'b1; addr[2] = 24'hABCDE0; wdat[2] = 16'h5A5A;
    @(negedge clk);
    check("rstw_issue", mem_w_en, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; mem_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; pw[2] = 1'b0; m_last = -1;
    check_reset("rst_wait");
    mem_cplt = 1'b1;
    @(negedge clk);
    mem_cplt = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstw_no_cplt", {ch_cplt, busy}, 0);
    end
    mem_rdy = 1'b1;

    // Four-channel ordering after a grant to ch1.
    @(negedge clk);
    pr = '0; pw = '0; en = '1; pr[1] = 1'b1;
    step(0, '0, g, we, din, nc);
    check("rr4_prime", g, 1);
    @(negedge clk);
    pr[3] = 1'b1; pr[1] = 1'b1; pr[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      step(0, '0, g, we, din, nc);
      check("rr4_order", g, exp_rr4[i]);
    end

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
        if (!(pr[c] || pw[c]) && ($urandom_range(0, 1) == 1)) begin
          k = $urandom_range(1, 3);
          pr[c] = k[0]; pw[c] = k[1];
          addr[c] = AW'($urandom); wdat[c] = DW'($urandom);
        end
      end
      en = ($urandom_range(0, 2) == 0) ? '1 : NCH'($urandom);
      mem_rdy = ($urandom_range(0, 4) != 0);
      step(0, '0, g, we, din, nc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel arbiter placed between the memory requesters (CPU, system init, display, future DMA) and `mem_cntrl`, replacing the fixed two-way `cpu_enable` mux. It accepts one outstanding read/write per channel, grants the single memory port to one channel at a time, issues a one-cycle command to `mem_cntrl`, and routes completion and read data back to the granted channel. Per-channel enables let the top level fence off requesters, such as the CPU during init, without holding them in reset.

## Interface
- `NUM_CH`, 2, number of requester channels (2..8); channel 0 is the lowest index.
- `ADDR_WIDTH`, 24, memory address width.
- `DATA_WIDTH`, 16, memory data width.
- `IDW`, `$clog2(NUM_CH)` (min 1), derived grant-index width; not overridden.

Ports. One clock; reset is synchronous and active-low.
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous active-low reset.
- `ch_en`  in  NUM_CH  per-channel enable; a disabled channel is never granted.
- `ch_addr`  in  NUM_CH*ADDR_WIDTH  flattened; channel i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `ch_data_in`  in  NUM_CH*DATA_WIDTH  write data, flattened the same way.
- `ch_r_en`, `ch_w_en`  in  NUM_CH  level requests, held until that channel's `ch_cplt`.
- `ch_rdy`  out  NUM_CH  arbiter idle, `mem_rdy`=1 and `ch_en[i]`=1.
- `ch_cplt`  out  NUM_CH  one-cycle completion pulse to the granted channel.
- `ch_data_out`  out  DATA_WIDTH  read data, shared by all channels; valid while `ch_cplt` is high.
- `mem_addr`  out  ADDR_WIDTH  to `mem_cntrl`.
- `mem_data_in`  out  DATA_WIDTH  to `mem_cntrl`.
- `mem_r_en`, `mem_w_en`  out  1  one-cycle command strobes.
- `mem_rdy`, `mem_cplt`  in  1  from `mem_cntrl`.
- `mem_data_out`  in  DATA_WIDTH  from `mem_cntrl`.
- `busy`  out  1  state ≠ IDLE.
- `grant_id`  out  IDW  index of the current or last granted channel.

## Operation
- A channel i is eligible when `ch_en[i]` and (`ch_r_en[i]` or `ch_w_en[i]`).
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if `mem_rdy` and at least one channel is eligible, select the winner, then latch `grant_id`, address, write data and op, and go to ISSUE.
  - ISSUE: drive exactly one of `mem_r_en`/`mem_w_en` for this single cycle, then go to WAIT.
  - WAIT: hold until `mem_cplt`. On `mem_cplt`, register `mem_data_out` into `ch_data_out` and go to DONE.
  - DONE: `ch_cplt[grant_id]`=1 for this cycle only, then go to IDLE.
- If a channel asserts `ch_r_en` and `ch_w_en` together, the write is performed.
- `mem_addr` and `mem_data_in` hold the latched values from ISSUE until the next grant.
- A request or enable change after grant has no effect on the operation in flight. A channel whose `ch_en` drops mid-operation still receives its `ch_cplt`.
- Requesters must deassert their request on the edge after `ch_cplt`. The arbiter samples again only in IDLE, so there is no re-grant hazard.
- Reset:
  - All outputs go to 0, state goes to IDLE, and the round-robin pointer goes to 0.
  - Reset during WAIT abandons the operation and no `ch_cplt` is issued. `mem_cntrl` is reset by the same source.

## Timing
- Grant edge: request seen in IDLE at cycle 0.
- Command: `mem_r_en`/`mem_w_en` high in cycle 1.
- Completion: `ch_cplt` high one cycle after the `mem_cplt` cycle.
- Minimum request-to-`ch_cplt` latency is (mem latency + 2) cycles. Minimum spacing between grants is 4 cycles.
- `ch_rdy` is registered-state combinational: it is low in all states except IDLE.
- No combinational path from any `ch_*` input to any `mem_*` output.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin. Search starts at (last `grant_id` + 1) mod NUM_CH.
  - The pointer updates only on a grant.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority; the lowest eligible index wins.
  - The round-robin pointer logic is removed.

## Test plan
- Single read: NUM_CH=2, ch1 reads 0x000010, memory returns 0xBEEF after 5 cycles → `mem_r_en` pulse in cycle 1, `ch_cplt`=2'b10 and `ch_data_out`=0xBEEF in cycle 7.
- Contention: ch0 and ch1 both request continuously → with `MEM_ARB_RR_EN`, grants go 0,1,0,1; without it, grants go 0,0,0.
- Disable: `ch_en`=2'b01, ch1 requests → no grant and `ch_rdy[1]`=0; setting `ch_en[1]`=1 produces a grant within 1 cycle of IDLE.
- R+W conflict: ch0 asserts both with `ch_data_in`=0x1234 → only `mem_w_en` pulses and `mem_data_in`=0x1234.
- Reset in WAIT: `rst_n`=0 for 1 cycle before `mem_cplt` → all outputs 0, state IDLE, no `ch_cplt`. A following request completes normally.
- NUM_CH=4 with `MEM_ARB_RR_EN`: channels 3, 1 and 2 request simultaneously after last grant=1 → order 2, 3, 1.
